// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
//   Memory-side bus between the load/store unit and the byte-addressed,
//   little-endian data memory. Memory read is combinational from mem_addr.
//   Memory write happens on the rising clock edge.
//   Ports (signals):
//     mem_we     LSU -> mem  write strobe
//     mem_be     LSU -> mem  byte-lane enables (lane n = bits 8n+7:8n)
//     mem_addr   LSU -> mem  word-aligned byte address
//     mem_wdata  LSU -> mem  lane-aligned write data
//     mem_rdata  mem -> LSU  word read data
//   Modports: master = LSU side, slave = memory side.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 32
);
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator between the core MEM stage and the data memory.
//   The unit takes one request at a time. It builds byte enables and
//   lane-shifted write data. An access that crosses a word boundary is
//   split into two word accesses. For loads, it merges, shifts and
//   sign/zero-extends the read data into one response.
//   Optional feature: define LSU_MISALIGN_TRAP_EN to trap naturally
//   misaligned H/HU/W accesses instead of executing them.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid/req_ready request handshake
//     req_we, req_funct3  store flag, RV32I width code
//     req_addr, req_wdata byte address, LSB-justified store data
//     rsp_valid           one-cycle completion pulse
//     rsp_rdata           extended load data (0 for stores)
//     rsp_misalign        misalignment trap flag
//     bus                 memory-side master modport
module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, lo_q, rdata_q;

  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic              valid_op, trap, access, do_split;
  logic [7:0]        be_wide;
  logic [63:0]       wd_wide;
  logic [ADDR_W-1:0] word_addr, next_word;
  logic [31:0]       hi_word, lo_word, raw, ext;

  assign off = addr_q[1:0];

  // Width decode. The reserved width codes leave valid_op low, so the
  // request goes through the normal latency without touching memory.
  always_comb begin
    size_mask = 4'b0000;
    valid_op  = 1'b1;
    case (f3_q)
      3'b000, 3'b100: size_mask = 4'b0001;
      3'b001, 3'b101: size_mask = 4'b0011;
      3'b010:         size_mask = 4'b1111;
      default:        valid_op  = 1'b0;
    endcase
  end

  // Shift the enables and data into a two-word window.
  // The low half drives the first access; the high half drives the
  // second access of a split.
  assign be_wide = {4'b0000, size_mask} << off;
  assign wd_wide = {32'h0, wdata_q} << {off, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  logic nat_misalign;
  assign nat_misalign = (f3_q[1:0] == 2'b01 && off[0]) ||
                        (f3_q[1:0] == 2'b10 && off != 2'b00);
  assign trap = valid_op && nat_misalign;
`else
  assign trap = 1'b0;
`endif

  assign access    = valid_op && !trap;
  assign do_split  = access && (be_wide[7:4] != 4'b0000);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign next_word = word_addr + ADDR_W'(4);

  // Load alignment. In ACC0 the live read word is the low half. In ACC1
  // the saved ACC0 word is the low half and the live read is the high half.
  assign hi_word = (state == ACC1) ? bus.mem_rdata : 32'h0;
  assign lo_word = (state == ACC1) ? lo_q : bus.mem_rdata;
  assign raw     = 32'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    ext = 32'h0;
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  ext = raw;
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
  end

  assign req_ready    = (state == IDLE) && rst_n;
  assign rsp_valid    = (state == RESP);
  assign rsp_rdata    = rsp_valid ? rdata_q : 32'h0;
  assign rsp_misalign = rsp_valid && trap;

  // State register and the held request fields.
  // The load result is captured at the end of the last access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
          end
        end
        ACC0: begin
          lo_q <= bus.mem_rdata;
          if (!do_split) begin
            rdata_q <= (access && !we_q) ? ext : 32'h0;
          end
        end
        ACC1: rdata_q <= we_q ? 32'h0 : ext;
        default: ;
      endcase
    end
  end

  // Next-state logic and memory bus drive.
  // The bus is quiet unless a real access is in progress.
  always_comb begin
    state_nxt     = state;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    case (state)
      IDLE: if (req_valid) state_nxt = ACC0;
      ACC0: begin
        if (access) begin
          bus.mem_we    = we_q;
          bus.mem_be    = be_wide[3:0];
          bus.mem_addr  = word_addr;
          bus.mem_wdata = wd_wide[31:0];
        end
        state_nxt = do_split ? ACC1 : RESP;
      end
      ACC1: begin
        bus.mem_we    = we_q;
        bus.mem_be    = be_wide[7:4];
        bus.mem_addr  = next_word;
        bus.mem_wdata = wd_wide[63:32];
        state_nxt     = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master
//   Directed bench for lsu_mem_master.
//   A byte-array model predicts:
//     - the bus activity of every access cycle
//     - the response of every request
//   A word memory attached to the DUT bus holds the real state. Stored data
//   therefore reaches later loads only through the DUT.
//   Build with LSU_MISALIGN_TRAP_EN defined to cover the trap variant.
module tb_lsu_mem_master;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;

  lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT: combinational read, posedge write.
  logic [31:0] mem_words [64];
  assign bus.mem_rdata = mem_words[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.mem_be[l]) mem_words[bus.mem_addr[7:2]][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
      end
    end
  end

  // Reference byte memory and the per-cycle expectation queue.
  logic [7:0] ref_mem [256];

  typedef struct packed {
    logic        rv;
    logic [31:0] rdata;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_mis = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = be[l] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      b = a + 8'(i);
      w[8*i +: 8] = ref_mem[b];
    end
    return w;
  endfunction

  // Compare process: every falling edge checks the DUT outputs against the
  // reset state, the next queued access-cycle expectation, or the idle state.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("rst_rsp_mis", 32'(rsp_misalign), 32'h0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'h0);
      checkOutput("rst_mem_be", 32'(bus.mem_be), 32'h0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      checkOutput("req_ready_busy", 32'(req_ready), 32'h0);
      checkOutput("mem_we", 32'(bus.mem_we), 32'(e.we));
      checkOutput("mem_be", 32'(bus.mem_be), 32'(e.be));
      if (e.be != 4'b0000) begin
        checkOutput("mem_addr", bus.mem_addr, e.addr);
        checkOutput("mem_wdata", bus.mem_wdata & lane_mask(e.be), e.wdata & lane_mask(e.be));
      end
      if (e.rv) begin
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
        last_rdata = rsp_rdata;
        last_mis   = rsp_misalign;
      end
    end else begin
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("idle_mem_we", 32'(bus.mem_we), 32'h0);
      checkOutput("idle_mem_be", 32'(bus.mem_be), 32'h0);
      checkOutput("idle_req_ready", 32'(req_ready), 32'h1);
    end
  end

  // Issue one request. Predict its cycle-by-cycle bus activity and response
  // from byte-level rules, then wait (bounded) for the compare process to
  // consume every prediction.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        pend[$];
    exp_t        e;
    int          size;
    logic        trapped;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, val, w0, ba;

    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    trapped = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trapped = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`endif
    be0 = 4'b0; be1 = 4'b0; wd0 = 32'h0; wd1 = 32'h0; val = 32'h0;
    w0  = addr & ~32'h3;
    if (size > 0 && !trapped) begin
      for (int i = 0; i < size; i++) begin
        ba = addr + 32'(i);
        if ((ba & ~32'h3) == w0) begin
          be0[ba[1:0]] = 1'b1;
          wd0[8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end else begin
          be1[ba[1:0]] = 1'b1;
          wd1[8*ba[1:0] +: 8] = wdata[8*i +: 8];
        end
        val[8*i +: 8] = ref_mem[ba[7:0]];
      end
    end
    if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
    if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
    if (we || size == 0 || trapped) val = 32'h0;

    e = '0;
    e.we = (size > 0 && !trapped) ? we : 1'b0;
    e.be = be0; e.addr = w0; e.wdata = wd0;
    pend.push_back(e);
    if (be1 != 4'b0000) begin
      e = '0;
      e.we = we; e.be = be1; e.addr = w0 + 32'h4; e.wdata = wd1;
      pend.push_back(e);
    end
    e = '0;
    e.rv = 1'b1; e.rdata = val; e.mis = trapped;
    pend.push_back(e);

    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b010;
    req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5A5A_5A5A;
    foreach (pend[k]) exp_q.push_back(pend[k]);
    if (we && size > 0 && !trapped) begin
      for (int i = 0; i < size; i++) begin
        ba = addr + 32'(i);
        ref_mem[ba[7:0]] = wdata[8*i +: 8];
      end
    end
    for (int c = 0; c < 8; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checkOutput("txn_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  // Accept a split store, then pull reset during its first access cycle.
  task automatic resetMidStore();
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h13; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int w = 0; w < 64; w++) mem_words[w] = 32'h0;
    mem_words[0]  = 32'h0000_BEEF;
    mem_words[4]  = 32'h8877_6655;
    mem_words[5]  = 32'hDDCC_BBAA;
    mem_words[63] = 32'h4433_2211;
    for (int b = 0; b < 256; b++) ref_mem[b] = mem_words[b/4][8*(b%4) +: 8];

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("lit_lw10", last_rdata, 32'h8877_6655);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
    checkOutput("lit_lb13", last_rdata, 32'hFFFF_FF88);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
    checkOutput("lit_lbu13", last_rdata, 32'h0000_0088);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0);
    checkOutput("lit_lhu12", last_rdata, 32'h0000_8877);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0);

    applyStimulus(1'b1, 3'b001, 32'h11, 32'h0000_1234);
    checkOutput("lit_sh_word", mem_words[4], 32'h8812_3455);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("lit_sh_readback", last_rdata, 32'h8812_3455);
    applyStimulus(1'b1, 3'b010, 32'h10, 32'h8877_6655);

`ifndef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 3'b010, 32'h12, 32'h0);
    checkOutput("lit_lw12_split", last_rdata, 32'hBBAA_8877);
    applyStimulus(1'b1, 3'b010, 32'h13, 32'hA1B2_C3D4);
    checkOutput("lit_sw13_w10", mem_words[4], 32'hD477_6655);
    checkOutput("lit_sw13_w14", mem_words[5], 32'hDDA1_B2C3);
    applyStimulus(1'b0, 3'b001, 32'h13, 32'h0);
    checkOutput("lit_lh13_split", last_rdata, 32'hFFFF_C3D4);
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
    checkOutput("lit_lw_wrap", last_rdata, 32'hBEEF_4433);
    applyStimulus(1'b1, 3'b000, 32'h15, 32'h0000_0077);
`else
    applyStimulus(1'b0, 3'b010, 32'h12, 32'h0);
    checkOutput("lit_trap_mis", 32'(last_mis), 32'h1);
    checkOutput("lit_trap_rdata", last_rdata, 32'h0);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
    checkOutput("lit_trap_lb13", last_rdata, 32'hFFFF_FF88);
    applyStimulus(1'b1, 3'b010, 32'h13, 32'hA1B2_C3D4);
    checkOutput("lit_trap_sw_w10", mem_words[4], 32'h8877_6655);
    applyStimulus(1'b0, 3'b101, 32'h11, 32'h0);
    applyStimulus(1'b0, 3'b101, 32'h12, 32'h0);
`endif

    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
    applyStimulus(1'b1, 3'b110, 32'h10, 32'hFFFF_FFFF);
    checkOutput("bad_f3_no_write", mem_words[4], ref_word(8'h10));

    resetMidStore();
    checkOutput("rst_w10_kept", mem_words[4], ref_word(8'h10));
    checkOutput("rst_w14_kept", mem_words[5], ref_word(8'h14));
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
